// File: rtl/id_ex_pipe_elastic.sv
// Elastic pipeline stage: main entry drives the outputs, a one-entry skid
// buffer absorbs the single bundle that arrives while downstream stalls.
// in_ready depends only on registered state, so there is no combinational
// path from out_ready back to in_ready.
module id_ex_pipe_elastic #(
  parameter int N      = 32,
  parameter int WORDS  = 3,
  parameter int REGS   = 3,
  parameter int CTRL_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDS*N-1:0]  in_data,
  input  logic [REGS*5-1:0]   in_regs,
  input  logic [CTRL_W-1:0]   in_ctrl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDS*N-1:0]  out_data,
  output logic [REGS*5-1:0]   out_regs,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [1:0]          occupancy
);

  logic               main_valid;
  logic [WORDS*N-1:0] main_data;
  logic [REGS*5-1:0]  main_regs;
  logic [CTRL_W-1:0]  main_ctrl;

  logic               skid_valid;
  logic [WORDS*N-1:0] skid_data;
  logic [REGS*5-1:0]  skid_regs;
  logic [CTRL_W-1:0]  skid_ctrl;

  logic accept;
  logic emit;

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && !skid_valid;
  assign emit      = main_valid && out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_regs  = main_regs;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occupancy = 2'(main_valid) + 2'(skid_valid);

  // Main/skid update: reset clears everything, flush kills both entries and
  // their control bits, otherwise main refills from skid first (FIFO order)
  // and only takes the input directly when skid is empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_regs  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_regs  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (!main_valid || emit) begin
      if (skid_valid) begin
        // accept is impossible here because in_ready is low while skid is full
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_regs  <= skid_regs;
        main_ctrl  <= skid_ctrl;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
        main_regs  <= in_regs;
        main_ctrl  <= in_ctrl;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_regs  <= in_regs;
      skid_ctrl  <= in_ctrl;
    end
  end

endmodule
